// File: rtl/c3po_cfg_pkg.sv
// Shared constants and types for the C-3PO slice configuration controller.
package c3po_cfg_pkg;

  // Per-port register offsets (addr[3:0])
  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_CNT0   = 4'd2;
  localparam logic [3:0] REG_CNT1   = 4'd3;

  // Global read-only version register
  localparam logic [7:0]  ADDR_VERSION = 8'hF0;
  localparam logic [31:0] VERSION_C    = 32'hC3B0_0001;

  // CTRL register field positions
  localparam int EN_BIT    = 0;
  localparam int ID_LSB    = 4;
  localparam int FORCE_BIT = 31;

  // Host bus handshake states
  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } bus_state_t;

endpackage

// File: rtl/c3po_cfg_port_slot.sv
// One slice's configuration slot: shadow register, pending flag and the
// committed id/enable that drive the slice. A shadow write is only committed
// while the slice's unpacker is idle; a forced write bypasses the shadow.
module c3po_cfg_port_slot
  import c3po_cfg_pkg::*;
#(
  parameter int PORT_IDX = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic       wr_force,
  input  logic       wr_en,
  input  logic [3:0] wr_id,
  input  logic       idle,
  output logic [3:0] cfg_id,
  output logic       cfg_enable,
  output logic       pending
);

  logic [3:0] shadow_id;
  logic       shadow_en;

  // Commit the shadow when idle, then let a same-cycle write overlay it so a
  // new write always wins over (and re-arms after) a commit of the old shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_id  <= 4'(PORT_IDX);
      shadow_en  <= 1'b0;
      cfg_id     <= 4'(PORT_IDX);
      cfg_enable <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (pending && idle) begin
        cfg_id     <= shadow_id;
        cfg_enable <= shadow_en;
        pending    <= 1'b0;
      end
      if (wr) begin
        shadow_id <= wr_id;
        shadow_en <= wr_en;
        if (wr_force) begin
          cfg_id     <= wr_id;
          cfg_enable <= wr_en;
          pending    <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/c3po_cfg_ctrl.sv
// Host register-access controller for the C-3PO slices. Decodes req/ack bus
// accesses, returns counters/status/version, and hands CTRL writes to the
// per-port slots that sequence reconfiguration safely.
module c3po_cfg_ctrl
  import c3po_cfg_pkg::*;
#(
  parameter int PORTS_P    = 4,
  parameter int CNT_SIZE_P = 8,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req,
  input  logic                                 rd_wr,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [DATA_W-1:0]                    write_val,
  output logic                                 ack,
  output logic                                 err,
  output logic [DATA_W-1:0]                    read_val,
  input  logic [PORTS_P-1:0]                   idle,
  input  logic [PORTS_P-1:0][CNT_SIZE_P-1:0]   cnt0_val,
  input  logic [PORTS_P-1:0][CNT_SIZE_P-1:0]   cnt1_val,
  output logic [PORTS_P-1:0][3:0]              cfg_port_id,
  output logic [PORTS_P-1:0]                   cfg_port_enable,
  output logic [PORTS_P-1:0]                   pending
);

  bus_state_t              state;
  logic [3:0]              port_idx;
  logic [3:0]              reg_idx;
  logic                    is_version;
  logic                    port_ok;
  logic                    capture;
  logic                    dec_err;
  logic [DATA_W-1:0]       dec_rdata;
  logic [PORTS_P-1:0]      ctrl_wr;
  logic [CNT_SIZE_P-1:0]   sel_cnt0;
  logic [CNT_SIZE_P-1:0]   sel_cnt1;
  logic [3:0]              sel_id;
  logic                    sel_en;
  logic                    sel_idle;
  logic                    sel_pend;
  logic                    unused_write_bits;

  assign port_idx   = addr[7:4];
  assign reg_idx    = addr[3:0];
  assign is_version = (addr == ADDR_VERSION);
  assign port_ok    = (32'(port_idx) < PORTS_P);
  assign capture    = (state == ST_IDLE) && req;

  assign unused_write_bits = ^{write_val[FORCE_BIT-1:ID_LSB+4], write_val[ID_LSB-1:EN_BIT+1]};

  // Select the addressed port's live values; out-of-range ports select zero
  always_comb begin
    sel_cnt0 = '0;
    sel_cnt1 = '0;
    sel_id   = '0;
    sel_en   = 1'b0;
    sel_idle = 1'b0;
    sel_pend = 1'b0;
    for (int i = 0; i < PORTS_P; i++) begin
      if (32'(port_idx) == i) begin
        sel_cnt0 = cnt0_val[i];
        sel_cnt1 = cnt1_val[i];
        sel_id   = cfg_port_id[i];
        sel_en   = cfg_port_enable[i];
        sel_idle = idle[i];
        sel_pend = pending[i];
      end
    end
  end

  // Decode the access into an error flag and read data (zero for writes/errors)
  always_comb begin
    dec_err   = 1'b0;
    dec_rdata = '0;
    if (is_version) begin
      dec_err = rd_wr;
      if (!rd_wr) dec_rdata = DATA_W'(VERSION_C);
    end else if (!port_ok) begin
      dec_err = 1'b1;
    end else begin
      case (reg_idx)
        REG_CTRL: begin
          if (!rd_wr) begin
            dec_rdata[ID_LSB +: 4] = sel_id;
            dec_rdata[EN_BIT]      = sel_en;
          end
        end
        REG_STATUS: begin
          if (rd_wr) dec_err = 1'b1;
          else       dec_rdata[1:0] = {sel_pend, sel_idle};
        end
        REG_CNT0: begin
          if (rd_wr) dec_err = 1'b1;
          else       dec_rdata = DATA_W'(sel_cnt0);
        end
        REG_CNT1: begin
          if (rd_wr) dec_err = 1'b1;
          else       dec_rdata = DATA_W'(sel_cnt1);
        end
        default: dec_err = 1'b1;
      endcase
    end
  end

  // One-cycle CTRL write strobe to the addressed slot, only for a valid access
  always_comb begin
    ctrl_wr = '0;
    if (capture && rd_wr && !is_version && port_ok && (reg_idx == REG_CTRL)) begin
      for (int i = 0; i < PORTS_P; i++) begin
        ctrl_wr[i] = (32'(port_idx) == i);
      end
    end
  end

  // Two-state bus handshake: capture in IDLE, registered ack pulse in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ack      <= 1'b0;
      err      <= 1'b0;
      read_val <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state    <= ST_RESP;
            ack      <= 1'b1;
            err      <= dec_err;
            read_val <= dec_rdata;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          ack      <= 1'b0;
          err      <= 1'b0;
          read_val <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < PORTS_P; g++) begin : g_port
    c3po_cfg_port_slot #(
      .PORT_IDX (g)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .wr         (ctrl_wr[g]),
      .wr_force   (write_val[FORCE_BIT]),
      .wr_en      (write_val[EN_BIT]),
      .wr_id      (write_val[ID_LSB +: 4]),
      .idle       (idle[g]),
      .cfg_id     (cfg_port_id[g]),
      .cfg_enable (cfg_port_enable[g]),
      .pending    (pending[g])
    );
  end

endmodule

// File: tb/tb_c3po_cfg_ctrl.sv
// Self-checking bench for c3po_cfg_ctrl: directed scenarios plus randomized
// accesses, checked against a register-level reference model of the ports.
module tb_c3po_cfg_ctrl;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             rd_wr;
  logic [7:0]       addr;
  logic [31:0]      write_val;
  logic             ack;
  logic             err;
  logic [31:0]      read_val;
  logic [3:0]       idle;
  logic [3:0][7:0]  cnt0_val;
  logic [3:0][7:0]  cnt1_val;
  logic [3:0][3:0]  cfg_port_id;
  logic [3:0]       cfg_port_enable;
  logic [3:0]       pending;

  int total = 0;
  int bad   = 0;

  // Reference model: committed config, shadow and pending per port
  logic [3:0] m_id    [4];
  logic       m_en    [4];
  logic [3:0] m_sh_id [4];
  logic       m_sh_en [4];
  logic       m_pend  [4];

  c3po_cfg_ctrl #(
    .PORTS_P    (4),
    .CNT_SIZE_P (8),
    .ADDR_W     (8),
    .DATA_W     (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .rd_wr           (rd_wr),
    .addr            (addr),
    .write_val       (write_val),
    .ack             (ack),
    .err             (err),
    .read_val        (read_val),
    .idle            (idle),
    .cnt0_val        (cnt0_val),
    .cnt1_val        (cnt1_val),
    .cfg_port_id     (cfg_port_id),
    .cfg_port_enable (cfg_port_enable),
    .pending         (pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < 4; p++) begin
      m_id[p]    = 4'(p);
      m_en[p]    = 1'b0;
      m_sh_id[p] = 4'(p);
      m_sh_en[p] = 1'b0;
      m_pend[p]  = 1'b0;
    end
  endfunction

  // Apply one clock of model rules: idle commits, then an optional CTRL write
  function automatic void model_advance(input int wp, input logic [31:0] wd);
    for (int p = 0; p < 4; p++) begin
      logic [3:0] nid;
      logic       nen;
      logic       npend;
      nid   = m_id[p];
      nen   = m_en[p];
      npend = m_pend[p];
      if (m_pend[p] && idle[p]) begin
        nid   = m_sh_id[p];
        nen   = m_sh_en[p];
        npend = 1'b0;
      end
      if (p == wp) begin
        m_sh_id[p] = wd[7:4];
        m_sh_en[p] = wd[0];
        if (wd[31]) begin
          nid   = wd[7:4];
          nen   = wd[0];
          npend = 1'b0;
        end else begin
          npend = 1'b1;
        end
      end
      m_id[p]   = nid;
      m_en[p]   = nen;
      m_pend[p] = npend;
    end
  endfunction

  // Expected err/read data for an access given the model state right now
  function automatic void exp_resp(input logic rw, input logic [7:0] a,
                                   output logic e, output logic [31:0] d);
    int p;
    int r;
    p = int'(a[7:4]);
    r = int'(a[3:0]);
    e = 1'b0;
    d = 32'h0;
    if (a == 8'hF0) begin
      e = rw;
      if (!rw) d = 32'hC3B0_0001;
    end else if (p >= 4 || r > 3) begin
      e = 1'b1;
    end else if (rw) begin
      e = (r != 0);
    end else begin
      case (r)
        0: d = {24'h0, m_id[p], 3'b000, m_en[p]};
        1: d = {30'h0, m_pend[p], idle[p]};
        2: d = {24'h0, cnt0_val[p]};
        default: d = {24'h0, cnt1_val[p]};
      endcase
    end
  endfunction

  // Advance one clock, then compare the configuration outputs with the model
  task automatic tick(input int wp, input logic [31:0] wd);
    if (reset) model_reset();
    else       model_advance(wp, wd);
    @(posedge clk);
    #1;
    checkOutput("cfg_id", 32'(cfg_port_id), {16'h0, m_id[3], m_id[2], m_id[1], m_id[0]});
    checkOutput("cfg_en", 32'(cfg_port_enable), {28'h0, m_en[3], m_en[2], m_en[1], m_en[0]});
    checkOutput("pending", 32'(pending), {28'h0, m_pend[3], m_pend[2], m_pend[1], m_pend[0]});
  endtask

  // One complete host access: capture cycle, ack cycle, back to idle
  task automatic applyStimulus(input logic rw, input logic [7:0] a, input logic [31:0] d,
                               output logic got_err, output logic [31:0] got_rd);
    logic        e;
    logic [31:0] rd;
    int          wp;
    exp_resp(rw, a, e, rd);
    wp = (rw && !e && a != 8'hF0 && a[3:0] == 4'h0) ? int'(a[7:4]) : -1;
    req       = 1'b1;
    rd_wr     = rw;
    addr      = a;
    write_val = d;
    checkOutput("ack_before", 32'(ack), 32'h0);
    tick(wp, d);
    req = 1'b0;
    got_err = err;
    got_rd  = read_val;
    checkOutput("ack", 32'(ack), 32'h1);
    checkOutput("err", 32'(err), 32'(e));
    checkOutput("read_val", read_val, rd);
    tick(-1, 32'h0);
    checkOutput("ack_drop", 32'(ack), 32'h0);
  endtask

  initial begin
    logic        ge;
    logic [31:0] gr;
    logic        e;
    logic [31:0] rd;
    logic [7:0]  a;
    logic [31:0] d;
    reset     = 1'b1;
    req       = 1'b0;
    rd_wr     = 1'b0;
    addr      = 8'h0;
    write_val = 32'h0;
    idle      = 4'hF;
    cnt0_val  = '0;
    cnt1_val  = '0;
    tick(-1, 32'h0);
    tick(-1, 32'h0);
    reset = 1'b0;
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_id", 32'(cfg_port_id), 32'h3210);
    tick(-1, 32'h0);

    // Reset-state CTRL read-back
    for (int p = 0; p < 4; p++) begin
      applyStimulus(1'b0, {4'(p), 4'h0}, 32'h0, ge, gr);
      checkOutput("t1_ctrl", gr, 32'(p) << 4);
      checkOutput("t1_err", 32'(ge), 32'h0);
    end

    // Shadow write committed at once when idle
    idle = 4'hF;
    applyStimulus(1'b1, 8'h20, 32'h51, ge, gr);
    checkOutput("t2_id", 32'(cfg_port_id[2]), 32'h5);
    checkOutput("t2_en", 32'(cfg_port_enable[2]), 32'h1);
    checkOutput("t2_pend", 32'(pending[2]), 32'h0);

    // Write held pending while busy, committed once idle rises
    idle = 4'b1101;
    applyStimulus(1'b1, 8'h10, 32'h71, ge, gr);
    for (int i = 0; i < 20; i++) tick(-1, 32'h0);
    checkOutput("t3_hold_id", 32'(cfg_port_id[1]), 32'h1);
    checkOutput("t3_hold_pend", 32'(pending[1]), 32'h1);
    idle = 4'hF;
    tick(-1, 32'h0);
    checkOutput("t3_id", 32'(cfg_port_id[1]), 32'h7);
    checkOutput("t3_en", 32'(cfg_port_enable[1]), 32'h1);
    checkOutput("t3_pend", 32'(pending[1]), 32'h0);

    // Forced write bypasses the idle wait
    idle = 4'b1101;
    applyStimulus(1'b1, 8'h10, 32'h8000_0031, ge, gr);
    checkOutput("t4_id", 32'(cfg_port_id[1]), 32'h3);
    checkOutput("t4_pend", 32'(pending[1]), 32'h0);

    // Force cancels a pending write
    applyStimulus(1'b1, 8'h10, 32'h0000_0090, ge, gr);
    applyStimulus(1'b1, 8'h10, 32'h8000_00A0, ge, gr);
    idle = 4'hF;
    tick(-1, 32'h0);
    checkOutput("t4_cancel_id", 32'(cfg_port_id[1]), 32'hA);

    // Counter, version and error accesses
    cnt0_val[3] = 8'hAB;
    applyStimulus(1'b0, 8'h32, 32'h0, ge, gr);
    checkOutput("t5_cnt0", gr, 32'h0000_00AB);
    applyStimulus(1'b0, 8'hF0, 32'h0, ge, gr);
    checkOutput("t5_ver", gr, 32'hC3B0_0001);
    applyStimulus(1'b0, 8'h50, 32'h0, ge, gr);
    checkOutput("t5_badport", 32'(ge), 32'h1);
    applyStimulus(1'b1, 8'h02, 32'hFFFF_FFFF, ge, gr);
    checkOutput("t5_rowrite", 32'(ge), 32'h1);

    // Write colliding with a commit on the same port
    idle = 4'b1110;
    applyStimulus(1'b1, 8'h00, 32'h21, ge, gr);
    idle = 4'hF;
    applyStimulus(1'b1, 8'h00, 32'h41, ge, gr);
    checkOutput("t_coll_id", 32'(cfg_port_id[0]), 32'h4);

    // Reset during an access with a write pending
    idle = 4'b1110;
    applyStimulus(1'b1, 8'h00, 32'h91, ge, gr);
    checkOutput("t6_pend_set", 32'(pending[0]), 32'h1);
    req   = 1'b1;
    rd_wr = 1'b0;
    addr  = 8'h00;
    reset = 1'b1;
    tick(-1, 32'h0);
    checkOutput("t6_noack", 32'(ack), 32'h0);
    checkOutput("t6_pend", 32'(pending), 32'h0);
    checkOutput("t6_id", 32'(cfg_port_id), 32'h3210);
    reset = 1'b0;
    exp_resp(1'b0, 8'h00, e, rd);
    tick(-1, 32'h0);
    req = 1'b0;
    checkOutput("t6_fresh_ack", 32'(ack), 32'h1);
    checkOutput("t6_fresh_rd", read_val, rd);
    tick(-1, 32'h0);

    // Randomized accesses with changing idle and counters
    for (int n = 0; n < 200; n++) begin
      idle     = 4'($urandom);
      cnt0_val = 32'($urandom);
      cnt1_val = 32'($urandom);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick(-1, 32'h0);
      case ($urandom_range(0, 9))
        0:       a = 8'hF0;
        1:       a = {4'($urandom_range(4, 15)), 4'($urandom_range(0, 3))};
        2:       a = {4'($urandom_range(0, 3)), 4'($urandom_range(4, 15))};
        default: a = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      endcase
      d = $urandom;
      d[31] = ($urandom_range(0, 3) == 0);
      applyStimulus(1'($urandom_range(0, 1)), a, d, ge, gr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
